// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK responder: FSM states, frame sizing,
// LED command prefix and the response packing used by RTL and bench alike.
package jstk_pkg;

  localparam int FRAME_BITS = 40;
  localparam logic [5:0] CMD_LED_PREFIX = 6'b100000;

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_e;

  // Byte order on the wire: X low, X high, Y low, Y high, buttons.
  function automatic logic [FRAME_BITS-1:0] pack_response(input logic [9:0] x,
                                                          input logic [9:0] y,
                                                          input logic [2:0] b);
    return {x[7:0], 6'b000000, x[9:8], y[7:0], 6'b000000, y[9:8], 5'b00000, b};
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with registered
// single-cycle rise and fall pulses derived from the synchronized level.
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/jstk_responder.sv
// SPI mode-0 responder emulating the PmodJSTK: returns X/Y/buttons in a
// 5-byte frame and captures the first MOSI byte as an LED command.
module jstk_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = jstk_pkg::FRAME_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] led,
  output logic [7:0] cmd_byte,
  output logic       frame_done,
  output logic       frame_error
);
  import jstk_pkg::*;

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CMD_BIT  = CNT_W'(7);
  localparam int RESP_BITS = jstk_pkg::FRAME_BITS;

  logic sclk_s, sclk_rise_s, sclk_fall_s;
  logic ss_s, ss_rise_s, ss_fall_s;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall, unused_sclk_level;
  logic [RESP_BITS-1:0] resp_s;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .dout(unused_sclk_level), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk), .rst(rst), .din(ss), .dout(ss_s), .rise(ss_rise_s), .fall(ss_fall_s)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi), .dout(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  assign sclk_s = unused_sclk_level;
  assign resp_s = pack_response(x_pos, y_pos, buttons);

  // miso_q carries the bit on the wire; tx_shift_q holds the bits still to go.
  state_e               state_q, state_d;
  logic [RESP_BITS-2:0] tx_shift_q, tx_shift_d;
  logic [6:0]           rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]           cmd_rx_q, cmd_rx_d;
  logic [7:0]           cmd_byte_q, cmd_byte_d;
  logic [1:0]           led_q, led_d;
  logic                 miso_q, miso_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_rx_d   = cmd_rx_q;
    cmd_byte_d = cmd_byte_q;
    led_d      = led_q;
    miso_d     = miso_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      WAIT_HIGH: begin
        miso_d = 1'b0;
        if (ss_s) state_d = IDLE;
        else      state_d = WAIT_HIGH;
      end
      IDLE: begin
        if (ss_fall_s) begin
          tx_shift_d = resp_s[RESP_BITS-2:0];
          miso_d     = resp_s[RESP_BITS-1];
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end else begin
          miso_d = 1'b0;
        end
      end
      SHIFT: begin
        // ss edges take priority; a coincident sclk edge is dropped.
        if (ss_rise_s) begin
          err_d   = 1'b1;
          miso_d  = 1'b0;
          state_d = IDLE;
        end else if (sclk_rise_s) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CMD_BIT) cmd_rx_d = {rx_shift_q, mosi_s};
          else                      cmd_rx_d = cmd_rx_q;
          // cmd_byte and led commit only when the frame completes.
          if (bit_cnt_q == LAST_BIT) begin
            done_d     = 1'b1;
            cmd_byte_d = cmd_rx_q;
            if (cmd_rx_q[7:2] == CMD_LED_PREFIX) led_d = cmd_rx_q[1:0];
            else                                 led_d = led_q;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else if (sclk_fall_s) begin
          miso_d     = tx_shift_q[RESP_BITS-2];
          tx_shift_d = {tx_shift_q[RESP_BITS-3:0], 1'b0};
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (ss_rise_s) state_d = IDLE;
        else           state_d = DONE;
      end
      default: begin
        miso_d  = 1'b0;
        state_d = WAIT_HIGH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= WAIT_HIGH;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      cmd_rx_q   <= 8'h00;
      cmd_byte_q <= 8'h00;
      led_q      <= 2'b00;
      miso_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      cmd_rx_q   <= cmd_rx_d;
      cmd_byte_q <= cmd_byte_d;
      led_q      <= led_d;
      miso_q     <= miso_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign miso        = miso_q;
  assign led         = led_q;
  assign cmd_byte    = cmd_byte_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;

endmodule

// File: tb/tb_jstk_responder.sv
// Directed bench for jstk_responder: table of frames plus hand-written
// sequences for input change, reset mid-frame and overrun.
module tb_jstk_responder;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [9:0] x_pos = 10'd0;
  logic [9:0] y_pos = 10'd0;
  logic [2:0] buttons = 3'b000;
  logic [1:0] led;
  logic [7:0] cmd_byte;
  logic       frame_done;
  logic       frame_error;

  jstk_responder #(.SYNC_STAGES(2), .FRAME_BITS(40)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons), .led(led),
    .cmd_byte(cmd_byte), .frame_done(frame_done), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int done_cnt = 0;
  int err_cnt = 0;
  always @(posedge clk) begin
    if (frame_done)  done_cnt <= done_cnt + 1;
    if (frame_error) err_cnt  <= err_cnt + 1;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI frame; miso sampled at the end of each low phase into got[47-i].
  task automatic run_frame(input logic [7:0] cmd, input int nbits, input int chg_bit,
                           input logic [9:0] chg_x, input int rst_bit, output logic [47:0] got);
    got = '0;
    ss = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 8) ? cmd[7-i] : 1'b0;
      wait_cyc(HALF);
      got[47-i] = miso;
      sclk = 1'b1;
      if (i == rst_bit) begin
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(HALF - 5);
      end else begin
        wait_cyc(HALF);
      end
      sclk = 1'b0;
      if (i == chg_bit) x_pos = chg_x;
    end
    wait_cyc(HALF);
    ss = 1'b1;
    mosi = 1'b0;
    wait_cyc(4 * HALF);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  b;
    int          nbits;
    logic [39:0] resp;
    logic [1:0]  exp_led;
    logic [7:0]  exp_cmd;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [47:0] got;
    logic [47:0] ones;
    logic [47:0] mask;
    int d0, e0;

    vecs[0] = '{8'h82, 10'd700, 10'd300, 3'b101, 40, 40'hBC022C0105, 2'b10, 8'h82, 1, 0};
    vecs[1] = '{8'h41, 10'd1023, 10'd0, 3'b010, 40, 40'hFF03000002, 2'b10, 8'h41, 1, 0};
    vecs[2] = '{8'h81, 10'd5, 10'd6, 3'b000, 17, 40'h0500060000, 2'b10, 8'h41, 0, 1};
    vecs[3] = '{8'h83, 10'd700, 10'd300, 3'b101, 40, 40'hBC022C0105, 2'b11, 8'h83, 1, 0};
    vecs[4] = '{8'h80, 10'd341, 10'd682, 3'b111, 48, 40'h5501AA0207, 2'b00, 8'h80, 1, 0};
    ones = '1;

    wait_cyc(5);
    check("reset_miso", 64'(miso), 64'd0);
    check("reset_led", 64'(led), 64'd0);
    check("reset_cmd", 64'(cmd_byte), 64'h00);
    check("reset_done", 64'(frame_done), 64'd0);
    check("reset_err", 64'(frame_error), 64'd0);
    rst = 1'b1;
    wait_cyc(20);

    for (int v = 0; v < 5; v++) begin
      x_pos = vecs[v].x;
      y_pos = vecs[v].y;
      buttons = vecs[v].b;
      d0 = done_cnt;
      e0 = err_cnt;
      run_frame(vecs[v].cmd, vecs[v].nbits, -1, 10'd0, -1, got);
      mask = ones << (48 - vecs[v].nbits);
      check($sformatf("v%0d_miso", v), 64'(got & mask), 64'({vecs[v].resp, 8'h00} & mask));
      check($sformatf("v%0d_done", v), 64'(done_cnt - d0), 64'(vecs[v].exp_done));
      check($sformatf("v%0d_err", v), 64'(err_cnt - e0), 64'(vecs[v].exp_err));
      check($sformatf("v%0d_led", v), 64'(led), 64'(vecs[v].exp_led));
      check($sformatf("v%0d_cmd", v), 64'(cmd_byte), 64'(vecs[v].exp_cmd));
    end

    // X changes after bit 4; the snapshot taken at ss fall must be sent.
    x_pos = 10'd512; y_pos = 10'd0; buttons = 3'b000;
    d0 = done_cnt;
    run_frame(8'h81, 40, 3, 10'd0, -1, got);
    check("chg_miso", 64'(got[47:8]), 64'h0002000000);
    check("chg_done", 64'(done_cnt - d0), 64'd1);
    check("chg_led", 64'(led), 64'(2'b01));
    check("chg_cmd", 64'(cmd_byte), 64'h81);

    // Reset during bit 20 with ss held low.
    x_pos = 10'd700; y_pos = 10'd300; buttons = 3'b101;
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(8'h82, 40, -1, 10'd0, 20, got);
    check("rst_pre_bits", 64'(got[47:27]), 64'(21'h178045));
    check("rst_post_miso", 64'(got[26:8]), 64'd0);
    check("rst_done", 64'(done_cnt - d0), 64'd0);
    check("rst_err", 64'(err_cnt - e0), 64'd0);
    check("rst_led", 64'(led), 64'd0);
    check("rst_cmd", 64'(cmd_byte), 64'h00);

    d0 = done_cnt;
    run_frame(8'h82, 40, -1, 10'd0, -1, got);
    check("post_rst_miso", 64'(got[47:8]), 64'hBC022C0105);
    check("post_rst_done", 64'(done_cnt - d0), 64'd1);
    check("post_rst_led", 64'(led), 64'(2'b10));
    check("post_rst_cmd", 64'(cmd_byte), 64'h82);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jstk_responder.md
# jstk_responder

Cycle-accurate SPI responder that emulates the PmodJSTK joystick module. It answers the 5-byte frames issued by the existing PmodJSTK initiator, returning 10-bit X/Y positions and three button bits, and it captures the LED command byte. It sits on the MISO/MOSI/SCLK/SS pins in place of the physical Pmod. It serves as the joystick model in the game-level testbench and as an on-board loopback when a second board drives the game.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth on SCLK/SS/MOSI (minimum 2)
- FRAME_BITS, 40, bits per frame (5 bytes)

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset; synchronous, active-low
- sclk  in  1  SPI clock from initiator, asynchronous to clk
- ss  in  1  slave select, active-low, asynchronous
- mosi  in  1  command data from initiator
- miso  out  1  response data, MSB first
- x_pos  in  10  joystick X value (0–1023), sampled at frame start
- y_pos  in  10  joystick Y value (0–1023), sampled at frame start
- buttons  in  3  {btn2, btn1, stick}, sampled at frame start
- led  out  2  LED state from the last valid command
- cmd_byte  out  8  first MOSI byte of the last completed frame
- frame_done  out  1  one-cycle pulse when a frame completes
- frame_error  out  1  one-cycle pulse when SS rises before FRAME_BITS

## Operation
- Response frame, MSB first: byte0 = x_pos[7:0], byte1 = {6'b0, x_pos[9:8]}, byte2 = y_pos[7:0], byte3 = {6'b0, y_pos[9:8]}, byte4 = {5'b0, buttons}. The initiator's 40-bit DOUT then reads {byte0 … byte4}.
- The mode is SPI mode 0. The responder updates MISO after SCLK falls. It samples MOSI on SCLK rise.
- Each of sclk, ss and mosi passes through SYNC_STAGES flops. sclk and ss also get rise/fall edge detects.
- States:
  - WAIT_HIGH: entered after reset. Ignores everything until synchronized ss = 1, then goes to IDLE. This keeps a frame that is mid-flight at reset from being decoded.
  - IDLE: on an ss falling edge, load tx_shift[39:0] with the snapshot, clear bit_cnt and rx_shift, drive miso = tx_shift[39], go to SHIFT.
  - SHIFT: on an sclk rise, rx_shift <= {rx_shift[6:0], mosi_s}. bit_cnt increments. When bit_cnt reaches 7, latch cmd_byte. On an sclk fall, tx_shift shifts left with 0 fill and miso follows tx_shift[39]. When bit_cnt reaches FRAME_BITS, go to DONE.
  - DONE: pulse frame_done once. If cmd_byte[7:2] = 6'b100000, led <= cmd_byte[1:0]; otherwise led holds. Extra SCLK edges are ignored and miso = 0. On an ss rise, go to IDLE.
- An ss rise while in SHIFT pulses frame_error and returns to IDLE. led and cmd_byte are not changed.
- With ss high, miso = 0.
- An sclk edge and an ss edge can be detected in the same cycle. An ss rise wins, and the sclk edge is discarded. An ss fall wins in the same way: the load happens and the sclk edge is ignored.
- x_pos, y_pos and buttons may change at any time. Only the value at the ss-fall cycle is transmitted.

## Timing
- Reset values: miso = 0, led = 2'b00, cmd_byte = 8'h00, frame_done = 0, frame_error = 0, state = WAIT_HIGH.
- The delay from a pin edge to its action is SYNC_STAGES + 1 clk cycles.
- The first MISO bit is valid SYNC_STAGES + 1 clk cycles after ss falls.
- Each later bit is valid SYNC_STAGES + 1 clk cycles after the sclk fall.
- The SCLK high and low times must each be ≥ 2·(SYNC_STAGES + 1) clk cycles. The SS setup before the first SCLK rise has the same minimum. The PmodJSTK initiator runs far slower than this.
- frame_done asserts one cycle after the 40th synchronized sclk rise. led updates in that same cycle.
- frame_error asserts one cycle after the synchronized ss rise.

## Structure
- Shared package jstk_pkg holds:
  - the state enum (WAIT_HIGH, IDLE, SHIFT, DONE)
  - FRAME_BITS
  - CMD_LED_PREFIX = 6'b100000
  - a function that packs {x, y, buttons} into the 40-bit response, also reused by the bench scoreboard
- One sub-module, spi_pin_sync: a SYNC_STAGES-deep synchronizer with registered rise/fall pulse outputs. It is instantiated for sclk, ss and mosi; the edge outputs are unused for mosi.

## Test plan
- Frame stimulus: x_pos = 10'd700, y_pos = 10'd300, buttons = 3'b101, initiator sends 8'h82 then 4 × 8'h00. Required: MISO stream 8'hBC, 8'h02, 8'h2C, 8'h01, 8'h05; frame_done pulses once; led = 2'b10; cmd_byte = 8'h82.
- Invalid command: first byte 8'h41. Required: led holds its previous value, cmd_byte = 8'h41, frame_done pulses once.
- Early abort: SS rises after 17 SCLK bits. Required: frame_error pulses once, no frame_done, led and cmd_byte unchanged. A following full frame returns correct data.
- Input change mid-frame: x_pos changes from 10'd512 to 10'd0 after bit 4. Required: the transmitted X is still 10'd512 (bytes 8'h00, 8'h02).
- Reset mid-frame: rst is low for 3 cycles during bit 20 while SS stays low. Required: reset values appear; no frame_done or frame_error for that frame; miso = 0 until SS toggles high then low; the next frame is correct.
- Overrun: 48 SCLK pulses in one frame. Required: frame_done pulses exactly once at bit 40, and miso = 0 for bits 41–48.
